// File: rtl/mig_7series_0_if.sv
// mig_7series_0_if: MIG user-interface bundle (command, write data, read data, maintenance)
// between user logic (master) and the memory controller (slave).
interface mig_7series_0_if;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         app_sr_req;
  logic         app_ref_req;
  logic         app_zq_req;
  logic         app_sr_active;
  logic         app_ref_ack;
  logic         app_zq_ack;
  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
           app_sr_req, app_ref_req, app_zq_req,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           app_sr_active, app_ref_ack, app_zq_ack
  );
  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
           app_sr_req, app_ref_req, app_zq_req,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           app_sr_active, app_ref_ack, app_zq_ack
  );
endinterface

// File: rtl/mig_7series_0.sv
// mig_7series_0: UI-level functional model of a 7-series DDR2 MIG; 4-deep command and
// write-data FIFOs feed an internal 128-bit word array, DDR2 pins are held idle.
module mig_7series_0 #(
  parameter int MEM_AW      = 10,
  parameter int INIT_CYCLES = 16,
  parameter int RD_LATENCY  = 4
) (
  input  logic        sys_clk_i,
  input  logic        clk_ref_i,
  input  logic        rst,
  output logic        ui_clk,
  output logic        ui_clk_sync_rst,
  output logic        init_calib_complete,
  mig_7series_0_if.slave app,
  inout  wire  [15:0] ddr2_dq,
  inout  wire  [1:0]  ddr2_dqs_p,
  inout  wire  [1:0]  ddr2_dqs_n,
  output logic [12:0] ddr2_addr,
  output logic [2:0]  ddr2_ba,
  output logic        ddr2_ras_n,
  output logic        ddr2_cas_n,
  output logic        ddr2_we_n,
  output logic        ddr2_ck_p,
  output logic        ddr2_ck_n,
  output logic        ddr2_cke,
  output logic [1:0]  ddr2_dm,
  output logic        ddr2_odt
);
  localparam int CW = $clog2(INIT_CYCLES + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              calib_q, calib_d, srst_q;
  logic [2:0]        c_cmd_q [4];
  logic [MEM_AW-1:0] c_idx_q [4];
  logic [2:0]        c_wp_q, c_rp_q, c_cnt;
  logic [127:0]      w_data_q [4];
  logic [15:0]       w_mask_q [4];
  logic [2:0]        w_wp_q, w_rp_q, w_cnt;
  logic [2:0]        head_cmd;
  logic [MEM_AW-1:0] head_idx;
  logic              head_v, ex_wr, ex_rd, c_pop, w_pop, c_push, w_push;
  logic              ref_ack_q, zq_ack_q;
  logic              vp_q [RD_LATENCY];
  logic [127:0]      dp_q [RD_LATENCY];
  logic [127:0]      mem_q [2**MEM_AW] = '{default: '0};
  logic              unused;
  assign ui_clk = sys_clk_i;
  assign unused = ^{clk_ref_i, app.app_wdf_end, app.app_sr_req, app.app_addr[26:MEM_AW+3], app.app_addr[2:0]};
  // Only the FIFO head can execute; a write waits for its data and blocks everything behind it.
  always_comb begin
    cnt_d = cnt_q + CW'(cnt_q != CW'(INIT_CYCLES));
    calib_d = calib_q | (cnt_q == CW'(INIT_CYCLES - 1));
    c_cnt = c_wp_q - c_rp_q;
    w_cnt = w_wp_q - w_rp_q;
    head_cmd = c_cmd_q[c_rp_q[1:0]];
    head_idx = c_idx_q[c_rp_q[1:0]];
    head_v = rst & (c_cnt != 3'd0);
    ex_wr = head_v & (head_cmd == 3'b000) & (w_cnt != 3'd0);
    ex_rd = head_v & (head_cmd == 3'b001);
    c_pop = head_v & ((head_cmd != 3'b000) | (w_cnt != 3'd0));
    w_pop = ex_wr;
    app.app_rdy = rst & calib_q & (!c_cnt[2] | c_pop);
    app.app_wdf_rdy = rst & calib_q & (!w_cnt[2] | w_pop);
    c_push = app.app_en & app.app_rdy;
    w_push = app.app_wdf_wren & app.app_wdf_rdy;
  end
  always_ff @(posedge ui_clk) begin
    srst_q <= !rst;
    if (!rst) begin
      cnt_q <= '0;
      calib_q <= 1'b0;
      c_wp_q <= '0;
      c_rp_q <= '0;
      w_wp_q <= '0;
      w_rp_q <= '0;
      ref_ack_q <= 1'b0;
      zq_ack_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      calib_q <= calib_d;
      c_wp_q <= c_wp_q + 3'(c_push);
      c_rp_q <= c_rp_q + 3'(c_pop);
      w_wp_q <= w_wp_q + 3'(w_push);
      w_rp_q <= w_rp_q + 3'(w_pop);
      ref_ack_q <= app.app_ref_req;
      zq_ack_q <= app.app_zq_req;
    end
  end
  always_ff @(posedge ui_clk) begin
    if (c_push) begin
      c_cmd_q[c_wp_q[1:0]] <= app.app_cmd;
      c_idx_q[c_wp_q[1:0]] <= app.app_addr[MEM_AW+2:3];
    end
    if (w_push) begin
      w_data_q[w_wp_q[1:0]] <= app.app_wdf_data;
      w_mask_q[w_wp_q[1:0]] <= app.app_wdf_mask;
    end
  end
  // The array is never reset so executed writes survive a mid-operation reset.
  always_ff @(posedge ui_clk) begin
    if (ex_wr)
      for (int b = 0; b < 16; b++)
        if (!w_mask_q[w_rp_q[1:0]][b]) mem_q[head_idx][8*b +: 8] <= w_data_q[w_rp_q[1:0]][8*b +: 8];
  end
  // Read pipeline; every stage only loads on a valid beat so the last stage holds the old data.
  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        vp_q[s] <= 1'b0;
        dp_q[s] <= '0;
      end
    end else begin
      vp_q[0] <= ex_rd;
      if (ex_rd) dp_q[0] <= mem_q[head_idx];
      for (int s = 1; s < RD_LATENCY; s++) begin
        vp_q[s] <= vp_q[s-1];
        if (vp_q[s-1]) dp_q[s] <= dp_q[s-1];
      end
    end
  end
  assign ui_clk_sync_rst       = srst_q;
  assign init_calib_complete   = calib_q;
  assign app.app_rd_data       = dp_q[RD_LATENCY-1];
  assign app.app_rd_data_valid = vp_q[RD_LATENCY-1];
  assign app.app_rd_data_end   = vp_q[RD_LATENCY-1];
  assign app.app_ref_ack       = ref_ack_q;
  assign app.app_zq_ack        = zq_ack_q;
  assign app.app_sr_active     = 1'b0;
  assign ddr2_dq    = 16'bz;
  assign ddr2_dqs_p = 2'bz;
  assign ddr2_dqs_n = 2'bz;
  assign ddr2_ck_p  = sys_clk_i;
  assign ddr2_ck_n  = ~sys_clk_i;
  assign ddr2_cke   = calib_q;
  assign ddr2_ras_n = 1'b1;
  assign ddr2_cas_n = 1'b1;
  assign ddr2_we_n  = 1'b1;
  assign ddr2_addr  = '0;
  assign ddr2_ba    = '0;
  assign ddr2_dm    = '0;
  assign ddr2_odt   = 1'b0;
endmodule

// File: tb/tb_mig_7series_0.sv
// tb_mig_7series_0: randomized + directed bench; a queue-based reference model predicts read
// data at command issue and a negedge monitor checks every read beat against it.
module tb_mig_7series_0;
  localparam int RDL = 4;
  logic sys_clk = 1'b0, clk_ref = 1'b0, rst = 1'b0;
  logic ui_clk, ui_clk_sync_rst, init_calib_complete;
  wire [15:0] ddr2_dq;
  wire [1:0]  ddr2_dqs_p, ddr2_dqs_n;
  logic [12:0] ddr2_addr;
  logic [2:0]  ddr2_ba;
  logic ddr2_ras_n, ddr2_cas_n, ddr2_we_n, ddr2_ck_p, ddr2_ck_n, ddr2_cke, ddr2_odt;
  logic [1:0]  ddr2_dm;
  int checks = 0, errors = 0;
  mig_7series_0_if app();
  mig_7series_0 dut (
    .sys_clk_i(sys_clk), .clk_ref_i(clk_ref), .rst(rst), .ui_clk(ui_clk),
    .ui_clk_sync_rst(ui_clk_sync_rst), .init_calib_complete(init_calib_complete), .app(app),
    .ddr2_dq(ddr2_dq), .ddr2_dqs_p(ddr2_dqs_p), .ddr2_dqs_n(ddr2_dqs_n), .ddr2_addr(ddr2_addr),
    .ddr2_ba(ddr2_ba), .ddr2_ras_n(ddr2_ras_n), .ddr2_cas_n(ddr2_cas_n), .ddr2_we_n(ddr2_we_n),
    .ddr2_ck_p(ddr2_ck_p), .ddr2_ck_n(ddr2_ck_n), .ddr2_cke(ddr2_cke), .ddr2_dm(ddr2_dm),
    .ddr2_odt(ddr2_odt)
  );
  always #5 sys_clk = ~sys_clk;
  always #3 clk_ref = ~clk_ref;
  // Reference model: memory image plus pending command / write-data queues.
  typedef struct { logic [2:0] cmd; int idx; } mc_t;
  logic [127:0] mm [1024];
  mc_t          mcq[$];
  logic [127:0] mdq[$];
  logic [15:0]  mkq[$];
  logic [127:0] exp_q[$];
  function automatic void resolve();
    while (mcq.size() > 0) begin
      if (mcq[0].cmd == 3'b000) begin
        if (mdq.size() == 0) break;
        for (int b = 0; b < 16; b++)
          if (!mkq[0][b]) mm[mcq[0].idx][8*b +: 8] = mdq[0][8*b +: 8];
        void'(mdq.pop_front());
        void'(mkq.pop_front());
      end else if (mcq[0].cmd == 3'b001) exp_q.push_back(mm[mcq[0].idx]);
      void'(mcq.pop_front());
    end
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge sys_clk) begin
    if (app.app_rd_data_valid) begin
      chk("rd_end", app.app_rd_data_end, 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got data %h expected no read beat", app.app_rd_data);
      end else chk("rd_data", app.app_rd_data, exp_q.pop_front());
    end
  end
  task automatic issue_cmd(input logic [2:0] cmd, input logic [26:0] addr);
    int n = 0;
    @(negedge sys_clk);
    while (!app.app_rdy && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    if (!app.app_rdy) chk("cmd_timeout", app.app_rdy, 1);
    else begin
      app.app_en = 1'b1; app.app_cmd = cmd; app.app_addr = addr;
      @(posedge sys_clk);
      mcq.push_back('{cmd, int'(addr[12:3])});
      resolve();
      #1 app.app_en = 1'b0;
    end
  endtask
  task automatic push_data(input logic [127:0] data, input logic [15:0] mask);
    int n = 0;
    @(negedge sys_clk);
    while (!app.app_wdf_rdy && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    if (!app.app_wdf_rdy) chk("wdf_timeout", app.app_wdf_rdy, 1);
    else begin
      app.app_wdf_wren = 1'b1; app.app_wdf_end = 1'b1; app.app_wdf_data = data; app.app_wdf_mask = mask;
      @(posedge sys_clk);
      mdq.push_back(data);
      mkq.push_back(mask);
      resolve();
      #1 begin app.app_wdf_wren = 1'b0; app.app_wdf_end = 1'b0; end
    end
  endtask
  task automatic write_both(input logic [26:0] addr, input logic [127:0] data, input logic [15:0] mask);
    int n = 0;
    @(negedge sys_clk);
    while (!(app.app_rdy && app.app_wdf_rdy) && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    if (!(app.app_rdy && app.app_wdf_rdy)) chk("wr_timeout", app.app_rdy & app.app_wdf_rdy, 1);
    else begin
      app.app_en = 1'b1; app.app_cmd = 3'b000; app.app_addr = addr;
      app.app_wdf_wren = 1'b1; app.app_wdf_end = 1'b1; app.app_wdf_data = data; app.app_wdf_mask = mask;
      @(posedge sys_clk);
      mcq.push_back('{3'b000, int'(addr[12:3])});
      mdq.push_back(data);
      mkq.push_back(mask);
      resolve();
      #1 begin app.app_en = 1'b0; app.app_wdf_wren = 1'b0; app.app_wdf_end = 1'b0; end
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mcq.size() != 0) && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    chk("idle_timeout", exp_q.size() + mcq.size(), 0);
    repeat (RDL + 4) @(negedge sys_clk);
  endtask
  task automatic do_reset();
    @(negedge sys_clk);
    rst = 1'b0;
    mcq.delete(); mdq.delete(); mkq.delete(); exp_q.delete();
    repeat (RDL + 2) @(negedge sys_clk);
    chk("rst_calib", init_calib_complete, 0);
    chk("rst_rdy", {app.app_rdy, app.app_wdf_rdy}, 0);
    chk("rst_valid", app.app_rd_data_valid, 0);
    chk("rst_sync", ui_clk_sync_rst, 1);
    chk("rst_rd_data", app.app_rd_data, 0);
    chk("rst_acks", {app.app_ref_ack, app.app_zq_ack}, 0);
  endtask
  task automatic release_rst();
    int n = 0;
    @(negedge sys_clk);
    rst = 1'b1;
    while (!init_calib_complete && n < 100) begin
      @(posedge sys_clk);
      #1 n++;
    end
    chk("calib_latency", n, 16);
    chk("calib_rdy", {app.app_rdy, app.app_wdf_rdy}, 2'b11);
    chk("sync_rst_low", ui_clk_sync_rst, 0);
  endtask
  task automatic read_latency(input logic [26:0] addr);
    int n = 0;
    issue_cmd(3'b001, addr);
    while (!app.app_rd_data_valid && n < 20) begin
      @(posedge sys_clk);
      #1 n++;
    end
    chk("rd_latency", n, RDL);
  endtask
  task automatic random_phase();
    logic [2:0] rc [60];
    logic [26:0] ra [60];
    int nw = 0;
    for (int i = 0; i < 60; i++) begin
      int r = $urandom_range(0, 99);
      int idx = ($urandom_range(0, 9) == 0) ? 1023 : $urandom_range(0, 7);
      rc[i] = (r < 45) ? 3'b000 : (r < 85) ? 3'b001 : 3'($urandom_range(2, 7));
      ra[i] = {14'($urandom), 10'(idx), 3'($urandom)};
      if (rc[i] == 3'b000) nw++;
    end
    fork
      for (int i = 0; i < 60; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge sys_clk);
        issue_cmd(rc[i], ra[i]);
      end
      for (int j = 0; j < nw; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        push_data({$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0);
      end
    join
    wait_idle();
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 1024; i++) mm[i] = '0;
    app.app_addr = '0; app.app_cmd = '0; app.app_en = 1'b0;
    app.app_wdf_data = '0; app.app_wdf_mask = '0; app.app_wdf_wren = 1'b0; app.app_wdf_end = 1'b0;
    app.app_sr_req = 1'b0; app.app_ref_req = 1'b0; app.app_zq_req = 1'b0;
    do_reset();
    release_rst();
    @(negedge sys_clk);
    #1;
    chk("ck_pair", {ddr2_ck_p, ddr2_ck_n, ui_clk}, {sys_clk, ~sys_clk, sys_clk});
    chk("pins_nop", {ddr2_cke, ddr2_ras_n, ddr2_cas_n, ddr2_we_n}, 4'b1111);
    chk("pins_zero", {ddr2_addr, ddr2_ba, ddr2_dm, ddr2_odt}, 0);
    chk("sr_active", app.app_sr_active, 0);
    @(negedge sys_clk) app.app_ref_req = 1'b1;
    @(posedge sys_clk) #1 chk("ref_ack_hi", {app.app_ref_ack, app.app_zq_ack}, 2'b10);
    @(negedge sys_clk) begin app.app_ref_req = 1'b0; app.app_zq_req = 1'b1; end
    @(posedge sys_clk) #1 chk("zq_ack_hi", {app.app_ref_ack, app.app_zq_ack}, 2'b01);
    @(negedge sys_clk) app.app_zq_req = 1'b0;
    @(posedge sys_clk) #1 chk("acks_lo", {app.app_ref_ack, app.app_zq_ack}, 2'b00);
    write_both(27'h000, {16{8'hAA}}, 16'h0);
    write_both(27'h010, {16{8'hBB}}, 16'h0);
    read_latency(27'h000);
    read_latency(27'h010);
    wait_idle();
    chk("hold_bb", app.app_rd_data, {16{8'hBB}});
    issue_cmd(3'b000, 27'h040);
    issue_cmd(3'b001, 27'h040);
    repeat (3) begin
      @(negedge sys_clk);
      chk("stall_no_valid", app.app_rd_data_valid, 0);
    end
    push_data({16{8'h5A}}, 16'h0);
    wait_idle();
    chk("late_data", app.app_rd_data, {16{8'h5A}});
    write_both(27'h080, {128{1'b1}}, 16'h0);
    write_both(27'h080, '0, 16'h00FF);
    issue_cmd(3'b001, 27'h080);
    wait_idle();
    chk("mask", app.app_rd_data, {64'h0, {64{1'b1}}});
    for (int i = 0; i < 4; i++) issue_cmd(3'b000, 27'((100 + i) << 3));
    @(negedge sys_clk);
    chk("cmd_full", app.app_rdy, 0);
    push_data(128'h1111, 16'h0);
    chk("full_pop_rdy", app.app_rdy, 1);
    fork
      issue_cmd(3'b000, 27'(104 << 3));
      for (int j = 0; j < 4; j++) push_data(128'(j + 2) * 128'h1_0000_0001, 16'h0);
    join
    for (int i = 0; i < 5; i++) issue_cmd(3'b001, 27'((100 + i) << 3));
    wait_idle();
    chk("drain_last", app.app_rd_data, 128'h5_0000_0005);
    random_phase();
    write_both(27'h200, {16{8'hC3}}, 16'h0);
    wait_idle();
    issue_cmd(3'b001, 27'h200);
    issue_cmd(3'b001, 27'h010);
    do_reset();
    release_rst();
    issue_cmd(3'b001, 27'h010);
    issue_cmd(3'b001, 27'h200);
    wait_idle();
    chk("persist", app.app_rd_data, {16{8'hC3}});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
